// File: rtl/dual_port_memory_responder_if.sv
// dual_port_memory_responder_if: request/response channels for the two cache memory ports.
interface dual_port_memory_responder_if;
    logic [24:0] memory_request_0;
    logic        memory_request_ready_0;
    logic [24:0] memory_request_1;
    logic        memory_request_ready_1;
    logic [15:0] memory_response_0;
    logic        memory_response_ready_0;
    logic [15:0] memory_response_1;
    logic        memory_response_ready_1;
    modport master (
        output memory_request_0, memory_request_ready_0, memory_request_1, memory_request_ready_1,
        input  memory_response_0, memory_response_ready_0, memory_response_1, memory_response_ready_1
    );
    modport slave (
        input  memory_request_0, memory_request_ready_0, memory_request_1, memory_request_ready_1,
        output memory_response_0, memory_response_ready_0, memory_response_1, memory_response_ready_1
    );
endinterface

// File: rtl/dual_port_memory_responder.sv
// dual_port_memory_responder: round-robin two-port 16-bit word memory with fixed-latency 4-phase responses.
module dual_port_memory_responder #(
    parameter int ADDR_W  = 16,
    parameter int LATENCY = 2
) (
    input logic clock,
    input logic reset,
    dual_port_memory_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam int WORDS = 2 ** (ADDR_W - 1);
    state_t state, state_n;
    logic [3:0] count, count_n;
    logic grant, grant_n, last_grant, last_grant_n;
    logic [24:0] req, req_n;
    logic [15:0] resp, resp_n;
    logic ready, ready_n;
    logic [15:0] mem [WORDS];
    logic [ADDR_W-2:0] idx;
    logic [15:0] word, merged;
    logic commit, granted_ready, r0, r1, win;
    assign r0 = bus.memory_request_ready_0;
    assign r1 = bus.memory_request_ready_1;
    // on a tie the port that did not win the previous tie goes first
    assign win = (r0 && r1) ? !last_grant : r1;
    assign idx = req[ADDR_W-1:1];
    assign word = mem[idx];
    assign merged = !req[24] ? word : req[0] ? {req[23:16], word[7:0]} : {word[15:8], req[23:16]};
    assign commit = state == WAIT && count == 4'd0;
    assign granted_ready = grant ? r1 : r0;
    always_comb begin
        state_n = state;
        count_n = count;
        grant_n = grant;
        last_grant_n = last_grant;
        req_n = req;
        resp_n = resp;
        ready_n = ready;
        case (state)
            IDLE: if (r0 || r1) begin
                grant_n = win;
                req_n = win ? bus.memory_request_1 : bus.memory_request_0;
                count_n = 4'(LATENCY - 1);
                last_grant_n = (r0 && r1) ? win : last_grant;
                state_n = WAIT;
            end
            WAIT: if (commit) begin
                resp_n = merged;
                ready_n = 1'b1;
                state_n = RESP;
            end else begin
                count_n = count - 4'd1;
            end
            RESP: if (!granted_ready) begin
                resp_n = 16'd0;
                ready_n = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            count <= 4'd0;
            grant <= 1'b0;
            last_grant <= 1'b1;
            req <= 25'd0;
            resp <= 16'd0;
            ready <= 1'b0;
        end else begin
            state <= state_n;
            count <= count_n;
            grant <= grant_n;
            last_grant <= last_grant_n;
            req <= req_n;
            resp <= resp_n;
            ready <= ready_n;
        end
    end
    // storage is never cleared; reset only suppresses a write that is about to commit
    always_ff @(posedge clock) begin
        if (commit && req[24] && !reset) mem[idx] <= merged;
    end
    assign bus.memory_response_0 = grant ? 16'd0 : resp;
    assign bus.memory_response_ready_0 = ready && !grant;
    assign bus.memory_response_1 = grant ? resp : 16'd0;
    assign bus.memory_response_ready_1 = ready && grant;
endmodule

// File: tb/tb_dual_port_memory_responder.sv
// tb_dual_port_memory_responder: randomized self-checking bench against a byte-array reference model.
module tb_dual_port_memory_responder;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [24:0] rq [2][2];
    logic        rv [2][2];
    logic [15:0] rs [2][2];
    logic        ry [2][2];
    bit [7:0] mm [65536];
    int n_checks = 0;
    int n_errors = 0;
    dual_port_memory_responder_if bus_a ();
    dual_port_memory_responder_if bus_b ();
    dual_port_memory_responder #(.ADDR_W(16), .LATENCY(2)) dut_a (.clock(clock), .reset(reset), .bus(bus_a));
    dual_port_memory_responder #(.ADDR_W(16), .LATENCY(1)) dut_b (.clock(clock), .reset(reset), .bus(bus_b));
    always #5 clock = ~clock;
    assign bus_a.memory_request_0 = rq[0][0];
    assign bus_a.memory_request_ready_0 = rv[0][0];
    assign bus_a.memory_request_1 = rq[0][1];
    assign bus_a.memory_request_ready_1 = rv[0][1];
    assign rs[0][0] = bus_a.memory_response_0;
    assign ry[0][0] = bus_a.memory_response_ready_0;
    assign rs[0][1] = bus_a.memory_response_1;
    assign ry[0][1] = bus_a.memory_response_ready_1;
    assign bus_b.memory_request_0 = rq[1][0];
    assign bus_b.memory_request_ready_0 = rv[1][0];
    assign bus_b.memory_request_1 = rq[1][1];
    assign bus_b.memory_request_ready_1 = rv[1][1];
    assign rs[1][0] = bus_b.memory_response_0;
    assign ry[1][0] = bus_b.memory_response_ready_0;
    assign rs[1][1] = bus_b.memory_response_1;
    assign ry[1][1] = bus_b.memory_response_ready_1;

    function automatic logic [15:0] mword(input logic [15:0] a);
        return {mm[a | 16'd1], mm[a & 16'hFFFE]};
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        for (int d = 0; d < 2; d++) for (int p = 0; p < 2; p++) begin
            rv[d][p] = 1'b0;
            rq[d][p] = 25'd0;
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_rdy(input int d, input int p, output int c, output bit other);
        c = -1;
        other = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock);
            #1;
            if (ry[d][1-p] !== 1'b0 || rs[d][1-p] !== 16'd0) other = 1'b1;
            if (ry[d][p] === 1'b1) begin
                c = i;
                break;
            end
        end
    endtask

    // one complete 4-phase transaction; lat counts edges from accept to ready rise
    task automatic xact(input int d, input int p, input bit wr, input logic [7:0] dat, input logic [15:0] a,
                        output logic [15:0] got, output int lat, output bit quiet, output bit fell);
        int c;
        bit other;
        @(negedge clock);
        rq[d][p] = {wr, dat, a};
        rv[d][p] = 1'b1;
        wait_rdy(d, p, c, other);
        got = rs[d][p];
        lat = c - 1;
        quiet = !other;
        @(negedge clock);
        rv[d][p] = 1'b0;
        @(posedge clock);
        #1;
        fell = ry[d][p] === 1'b0 && rs[d][p] === 16'd0;
        if (wr && c > 0) mm[a] = dat;
    endtask

    task automatic init_region();
        logic [15:0] g;
        int l;
        bit q, f;
        for (int a = 0; a < 128; a++) xact(0, 0, 1'b1, 8'h00, 16'(a), g, l, q, f);
        xact(0, 0, 1'b1, 8'h00, 16'hFFFE, g, l, q, f);
        xact(0, 0, 1'b1, 8'h00, 16'hFFFF, g, l, q, f);
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        for (int d = 0; d < 2; d++) for (int p = 0; p < 2; p++) begin
            n_checks++;
            if (ry[d][p] !== 1'b0 || rs[d][p] !== 16'd0) begin
                n_errors++;
                $display("FAIL reset d%0d p%0d: ready=%b resp=%h, required 0/0000", d, p, ry[d][p], rs[d][p]);
            end
        end
    endtask

    task automatic test_basic();
        logic [15:0] g;
        int l;
        bit q, f;
        xact(0, 0, 1'b1, 8'd16, 16'h0017, g, l, q, f);
        n_checks++;
        if (g !== 16'h1000) begin n_errors++; $display("FAIL write0 resp: %h, required 1000", g); end
        n_checks++;
        if (l !== 2) begin n_errors++; $display("FAIL write0 latency: %0d, required 2", l); end
        n_checks++;
        if (!q) begin n_errors++; $display("FAIL write0 port1 quiet: activity seen, required none"); end
        xact(0, 1, 1'b0, 8'h00, 16'h0016, g, l, q, f);
        n_checks++;
        if (g !== 16'h1000) begin n_errors++; $display("FAIL read1 resp: %h, required 1000", g); end
        n_checks++;
        if (!f) begin n_errors++; $display("FAIL read1 release: ready/resp not cleared one edge after drop"); end
    endtask

    task automatic test_tie();
        int c;
        bit other;
        logic [15:0] g;
        do_reset();
        @(negedge clock);
        rq[0][0] = {1'b0, 8'h00, 16'h0016};
        rq[0][1] = {1'b0, 8'h00, 16'h0017};
        rv[0][0] = 1'b1;
        rv[0][1] = 1'b1;
        wait_rdy(0, 0, c, other);
        g = rs[0][0];
        n_checks++;
        if (c !== 3 || other) begin n_errors++; $display("FAIL tie1 port0 first: edges=%0d other=%b, required 3/0", c, other); end
        n_checks++;
        if (g !== mword(16'h0016)) begin n_errors++; $display("FAIL tie1 resp0: %h, required %h", g, mword(16'h0016)); end
        @(negedge clock);
        rv[0][0] = 1'b0;
        wait_rdy(0, 1, c, other);
        g = rs[0][1];
        n_checks++;
        if (c !== 4) begin n_errors++; $display("FAIL tie1 port1 after release: edges=%0d, required 4", c); end
        n_checks++;
        if (g !== mword(16'h0017)) begin n_errors++; $display("FAIL tie1 resp1: %h, required %h", g, mword(16'h0017)); end
        @(negedge clock);
        rv[0][1] = 1'b0;
        @(negedge clock);
        rv[0][0] = 1'b1;
        rv[0][1] = 1'b1;
        wait_rdy(0, 1, c, other);
        n_checks++;
        if (c !== 3 || other) begin n_errors++; $display("FAIL tie2 port1 first: edges=%0d other=%b, required 3/0", c, other); end
        @(negedge clock);
        rv[0][1] = 1'b0;
        wait_rdy(0, 0, c, other);
        n_checks++;
        if (c !== 4) begin n_errors++; $display("FAIL tie2 port0 second: edges=%0d, required 4", c); end
        @(negedge clock);
        rv[0][0] = 1'b0;
        @(posedge clock);
    endtask

    task automatic test_overwrite();
        logic [15:0] g;
        int l;
        bit q, f;
        xact(0, 0, 1'b1, 8'hFF, 16'h0022, g, l, q, f);
        xact(0, 1, 1'b1, 8'h80, 16'h0022, g, l, q, f);
        n_checks++;
        if (g !== 16'h0080) begin n_errors++; $display("FAIL overwrite resp: %h, required 0080", g); end
        for (int p = 0; p < 2; p++) begin
            xact(0, p, 1'b0, 8'h00, 16'h0022, g, l, q, f);
            n_checks++;
            if (g !== 16'h0080) begin n_errors++; $display("FAIL overwrite read p%0d: %h, required 0080", p, g); end
        end
    endtask

    task automatic test_reset_abort();
        logic [15:0] g;
        int l;
        bit q, f, seen;
        seen = 1'b0;
        @(negedge clock);
        rq[0][0] = {1'b1, 8'hAA, 16'h0040};
        rv[0][0] = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b1;
        rv[0][0] = 1'b0;
        repeat (3) begin
            @(posedge clock);
            #1;
            if (ry[0][0] !== 1'b0) seen = 1'b1;
        end
        reset = 1'b0;
        repeat (3) begin
            @(posedge clock);
            #1;
            if (ry[0][0] !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin n_errors++; $display("FAIL abort ready: ready rose, required 0"); end
        xact(0, 1, 1'b0, 8'h00, 16'h0040, g, l, q, f);
        n_checks++;
        if (g !== 16'h0000) begin n_errors++; $display("FAIL abort read: %h, required 0000", g); end
    endtask

    task automatic test_hold();
        int c, bad;
        bit other;
        logic [15:0] g;
        bad = 0;
        @(negedge clock);
        rq[0][1] = {1'b0, 8'h00, 16'h0017};
        rv[0][1] = 1'b1;
        wait_rdy(0, 1, c, other);
        g = rs[0][1];
        for (int i = 0; i < 20; i++) begin
            if (i == 5) rq[0][1] = {1'b1, 8'h55, 16'h0017};
            @(posedge clock);
            #1;
            if (ry[0][1] !== 1'b1 || rs[0][1] !== g) bad++;
        end
        n_checks++;
        if (g !== mword(16'h0017)) begin n_errors++; $display("FAIL hold resp: %h, required %h", g, mword(16'h0017)); end
        n_checks++;
        if (bad != 0) begin n_errors++; $display("FAIL hold stable: %0d unstable cycles, required 0", bad); end
        @(negedge clock);
        rv[0][1] = 1'b0;
        @(posedge clock);
    endtask

    task automatic test_boundary();
        logic [15:0] g;
        int l;
        bit q, f;
        xact(0, 1, 1'b1, 8'h5A, 16'hFFFF, g, l, q, f);
        xact(0, 0, 1'b0, 8'h00, 16'hFFFE, g, l, q, f);
        n_checks++;
        if (g !== 16'h5A00) begin n_errors++; $display("FAIL top word: %h, required 5A00", g); end
        xact(0, 1, 1'b0, 8'h00, 16'h0000, g, l, q, f);
        n_checks++;
        if (g !== mword(16'h0000)) begin n_errors++; $display("FAIL no wrap word0: %h, required %h", g, mword(16'h0000)); end
    endtask

    task automatic test_random();
        logic [15:0] g, a, e;
        logic [7:0] dat;
        int l, p;
        bit q, f, wr;
        for (int i = 0; i < 40; i++) begin
            p = int'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            dat = 8'($urandom);
            a = ($urandom_range(0, 7) == 0) ? 16'hFFFE | 16'($urandom_range(0, 1)) : 16'($urandom_range(0, 127));
            e = mword(a);
            if (wr) e = a[0] ? {dat, e[7:0]} : {e[15:8], dat};
            xact(0, p, wr, dat, a, g, l, q, f);
            n_checks++;
            if (g !== e || l !== 2 || !q || !f) begin
                n_errors++;
                $display("FAIL random %0d p%0d wr%0b a=%h: resp=%h lat=%0d quiet=%b fell=%b, required %h/2/1/1",
                         i, p, wr, a, g, l, q, f, e);
            end
        end
    endtask

    task automatic test_latency_one();
        logic [15:0] g;
        int l;
        bit q, f;
        xact(1, 0, 1'b1, 8'h3C, 16'h0020, g, l, q, f);
        n_checks++;
        if (l !== 1) begin n_errors++; $display("FAIL lat1 write latency: %0d, required 1", l); end
        xact(1, 1, 1'b1, 8'hC3, 16'h0021, g, l, q, f);
        xact(1, 0, 1'b0, 8'h00, 16'h0021, g, l, q, f);
        n_checks++;
        if (g !== 16'hC33C || l !== 1) begin n_errors++; $display("FAIL lat1 read: resp=%h lat=%0d, required C33C/1", g, l); end
    endtask

    initial begin
        test_reset();
        init_region();
        test_basic();
        test_tie();
        test_overwrite();
        test_reset_abort();
        test_hold();
        test_boundary();
        test_random();
        test_latency_one();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
